// File: rtl/pci_registered_io_bank_if.sv
// Core-side signals of one PCI registered IO bank: next-state drive controls from
// the master/target state machines and the received data / parity status back to them.
interface pci_registered_io_bank_if #(parameter int WIDTH = 36);
  logic [WIDTH-1:0] pci_ad_out_next;
  logic             pci_ad_out_en_next;
  logic             pci_ad_oe_next;
  logic             parity_check_en;
  logic [WIDTH-1:0] pci_ad_in_comb;
  logic [WIDTH-1:0] pci_ad_in_prev;
  logic             pci_par_in_prev;
  logic             parity_error;
  logic             pci_ad_oe_q;

  modport master (
    output pci_ad_out_next, pci_ad_out_en_next, pci_ad_oe_next, parity_check_en,
    input  pci_ad_in_comb, pci_ad_in_prev, pci_par_in_prev, parity_error, pci_ad_oe_q
  );

  modport slave (
    input  pci_ad_out_next, pci_ad_out_en_next, pci_ad_oe_next, parity_check_en,
    output pci_ad_in_comb, pci_ad_in_prev, pci_par_in_prev, parity_error, pci_ad_oe_q
  );
endinterface

// File: rtl/pci_registered_io_bank.sv
// WIDTH-bit bank of registered PCI pads sharing one PAR pin: output/OE flops,
// even-parity generation one clock behind AD, and a two-stage received-parity check.
module pci_registered_io_bank #(
  parameter int WIDTH       = 36,
  parameter bit BYPASS_MODE = 1'b0
) (
  input  logic              pci_clk,
  input  logic              pci_reset_comb,
  inout  wire  [WIDTH-1:0]  pci_ad_ext,
  inout  wire               pci_par_ext,
  pci_registered_io_bank_if.slave bank
);

  logic [WIDTH-1:0] ad_q, ad_d;
  logic [WIDTH-1:0] ad_in_prev_q, ad_in;
  logic             oe_q;
  logic             par_q, par_d, par_oe_q;
  logic             par_in_prev_q, par_in;
  logic             calc_q, calc_d, chk_q;
  logic             perr_q, perr_d;

  assign pci_ad_ext  = oe_q     ? ad_q  : {WIDTH{1'bz}};
  assign pci_par_ext = par_oe_q ? par_q : 1'bz;

  // Loopback lets the receive path see our own data while driving, independent of the pins.
  generate
    if (BYPASS_MODE) begin : g_bypass
      assign ad_in  = oe_q     ? ad_q  : pci_ad_ext;
      assign par_in = par_oe_q ? par_q : pci_par_ext;
    end else begin : g_pins
      assign ad_in  = pci_ad_ext;
      assign par_in = pci_par_ext;
    end
  endgenerate

  always_comb begin
    ad_d   = bank.pci_ad_out_en_next ? bank.pci_ad_out_next : ad_q;
    par_d  = ^ad_q;
    calc_d = ^ad_in;
    perr_d = chk_q & (calc_q ^ par_in);
  end

  always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
    if (pci_reset_comb) begin
      ad_q          <= '0;
      oe_q          <= 1'b0;
      par_q         <= 1'b0;
      par_oe_q      <= 1'b0;
      ad_in_prev_q  <= '0;
      par_in_prev_q <= 1'b0;
      calc_q        <= 1'b0;
      chk_q         <= 1'b0;
      perr_q        <= 1'b0;
    end else begin
      ad_q          <= ad_d;
      oe_q          <= bank.pci_ad_oe_next;
      par_q         <= par_d;
      par_oe_q      <= oe_q;
      ad_in_prev_q  <= ad_in;
      par_in_prev_q <= par_in;
      calc_q        <= calc_d;
      chk_q         <= bank.parity_check_en;
      perr_q        <= perr_d;
    end
  end

  assign bank.pci_ad_in_comb  = ad_in;
  assign bank.pci_ad_in_prev  = ad_in_prev_q;
  assign bank.pci_par_in_prev = par_in_prev_q;
  assign bank.parity_error    = perr_q;
  assign bank.pci_ad_oe_q     = oe_q;

`ifndef SYNTHESIS
  // Contention on the bus shows up as the pins disagreeing with what we drive.
  always_ff @(posedge pci_clk)
    if (!pci_reset_comb && oe_q && (pci_ad_ext !== ad_q))
      $warning("%m: AD pins %h differ from driven %h at %0t", pci_ad_ext, ad_q, $time);
`endif

endmodule

// File: tb/tb_pci_registered_io_bank.sv
// Bench for pci_registered_io_bank: directed vector table, randomized run against a
// cycle-history reference model, reset-mid-transfer and bypass loopback sequences.
module tb_pci_registered_io_bank;
  localparam int         W    = 36;
  localparam int         NR   = 200;
  localparam int         NV   = 20;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wire [W-1:0] ad_pins, b_ad_pins;
  wire         par_pin, b_par_pin;

  logic         xe = 1'b0, pe = 1'b0, xpar = 1'b0, b_xe = 1'b0;
  logic [W-1:0] xad = '0, b_xad = '0;

  assign ad_pins   = xe   ? xad   : {W{1'bz}};
  assign par_pin   = pe   ? xpar  : 1'bz;
  assign b_ad_pins = b_xe ? b_xad : {W{1'bz}};

  // Idle bus floats high through the board pull-ups.
  pullup (ad_pins);
  pullup (par_pin);
  pullup (b_ad_pins);
  pullup (b_par_pin);

  pci_registered_io_bank_if #(.WIDTH(W)) m_if ();
  pci_registered_io_bank_if #(.WIDTH(W)) b_if ();

  pci_registered_io_bank #(.WIDTH(W), .BYPASS_MODE(1'b0)) u_dut (
    .pci_clk(clk), .pci_reset_comb(rst),
    .pci_ad_ext(ad_pins), .pci_par_ext(par_pin), .bank(m_if));

  pci_registered_io_bank #(.WIDTH(W), .BYPASS_MODE(1'b1)) u_byp (
    .pci_clk(clk), .pci_reset_comb(rst),
    .pci_ad_ext(b_ad_pins), .pci_par_ext(b_par_pin), .bank(b_if));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [W-1:0] on, input logic en, input logic oe,
                       input logic x_e, input logic [W-1:0] x_ad,
                       input logic p_e, input logic x_par, input logic c_e);
    m_if.pci_ad_out_next    = on;
    m_if.pci_ad_out_en_next = en;
    m_if.pci_ad_oe_next     = oe;
    m_if.parity_check_en    = c_e;
    xe   = x_e;
    xad  = x_ad;
    pe   = p_e;
    xpar = x_par;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    b_if.pci_ad_out_next = '0; b_if.pci_ad_out_en_next = 1'b0;
    b_if.pci_ad_oe_next = 1'b0; b_if.parity_check_en = 1'b0;
    b_xe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed vectors: inputs for cycle c and the pin/error values expected during cycle c.
  typedef struct {
    logic [W-1:0] on;  logic en; logic oe;
    logic x_e; logic [W-1:0] x_ad; logic p_e; logic x_par; logic c_e;
    logic [W-1:0] e_ad; logic e_par; logic e_perr;
  } vec_t;

  function automatic vec_t mv(logic [W-1:0] on, logic en, logic oe, logic x_e, logic [W-1:0] x_ad,
                              logic p_e, logic x_par, logic c_e,
                              logic [W-1:0] e_ad, logic e_par, logic e_perr);
    vec_t v;
    v.on = on; v.en = en; v.oe = oe; v.x_e = x_e; v.x_ad = x_ad;
    v.p_e = p_e; v.x_par = x_par; v.c_e = c_e;
    v.e_ad = e_ad; v.e_par = e_par; v.e_perr = e_perr;
    return v;
  endfunction

  vec_t tv [NV];

  // Randomized-run history, one entry per clock cycle after reset release.
  logic [W-1:0] r_on [NR];
  logic [W-1:0] r_xad[NR];
  logic         r_en [NR], r_oe[NR], r_xe[NR], r_pe[NR], r_xpar[NR], r_ce[NR];

  function automatic logic [W-1:0] m_adq(int c);
    logic [W-1:0] v = '0;
    for (int j = 0; j < c; j++) if (r_en[j]) v = r_on[j];
    return v;
  endfunction
  function automatic logic m_oeq(int c);
    return (c > 0) ? r_oe[c-1] : 1'b0;
  endfunction
  function automatic logic [W-1:0] m_adpin(int c);
    if (m_oeq(c)) return m_adq(c);
    return r_xe[c] ? r_xad[c] : ONES;
  endfunction
  function automatic logic m_paroe(int c);
    return (c > 0) ? m_oeq(c-1) : 1'b0;
  endfunction
  function automatic logic m_parpin(int c);
    if (m_paroe(c)) return ^m_adq(c-1);
    return r_pe[c] ? r_xpar[c] : 1'b1;
  endfunction
  function automatic logic m_perr(int c);
    if (c < 2) return 1'b0;
    return r_ce[c-2] & (^m_adpin(c-2) ^ m_parpin(c-1));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a5;
    drive('0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    b_if.pci_ad_out_next = '0; b_if.pci_ad_out_en_next = 1'b0;
    b_if.pci_ad_oe_next = 1'b0; b_if.parity_check_en = 1'b0;

    tv[0]  = mv(36'h1,    1, 1, 0, '0,    0, 0, 0, ONES,    1, 0);
    tv[1]  = mv(36'h3,    1, 1, 0, '0,    0, 0, 0, 36'h1,   1, 0);
    tv[2]  = mv(36'h3,    0, 1, 0, '0,    0, 0, 0, 36'h3,   1, 0);
    tv[3]  = mv(36'h55,   0, 1, 0, '0,    0, 0, 0, 36'h3,   0, 0);
    tv[4]  = mv(36'hAA,   0, 1, 0, '0,    0, 0, 0, 36'h3,   0, 0);
    tv[5]  = mv(36'hF0,   0, 0, 0, '0,    0, 0, 0, 36'h3,   0, 0);
    tv[6]  = mv('0,       0, 0, 0, '0,    0, 0, 0, ONES,    0, 0);
    tv[7]  = mv('0,       0, 0, 1, 36'h7, 0, 0, 1, 36'h7,   1, 0);
    tv[8]  = mv('0,       0, 0, 0, '0,    1, 1, 0, ONES,    1, 0);
    tv[9]  = mv('0,       0, 0, 1, 36'h7, 0, 0, 1, 36'h7,   1, 0);
    tv[10] = mv('0,       0, 0, 0, '0,    1, 0, 0, ONES,    0, 0);
    tv[11] = mv('0,       0, 0, 0, '0,    0, 0, 0, ONES,    1, 1);
    tv[12] = mv('0,       0, 0, 0, '0,    0, 0, 0, ONES,    1, 0);
    tv[13] = mv('0,       0, 0, 1, 36'h7, 0, 0, 1, 36'h7,   1, 0);
    tv[14] = mv('0,       0, 0, 1, 36'h3, 1, 1, 1, 36'h3,   1, 0);
    tv[15] = mv('0,       0, 0, 1, 36'h1, 1, 1, 1, 36'h1,   1, 0);
    tv[16] = mv('0,       0, 0, 1, 36'hF, 1, 1, 1, 36'hF,   1, 1);
    tv[17] = mv('0,       0, 0, 0, '0,    1, 1, 0, ONES,    1, 0);
    tv[18] = mv('0,       0, 0, 0, '0,    0, 0, 0, ONES,    1, 1);
    tv[19] = mv('0,       0, 0, 0, '0,    0, 0, 0, ONES,    1, 0);

    // Reset state, held from time zero.
    #2;
    chk("reset oe_q",      m_if.pci_ad_oe_q,     '0);
    chk("reset perr",      m_if.parity_error,    '0);
    chk("reset ad_prev",   m_if.pci_ad_in_prev,  '0);
    chk("reset par_prev",  m_if.pci_par_in_prev, '0);
    chk("reset ad pins",   ad_pins,              ONES);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].on, tv[i].en, tv[i].oe, tv[i].x_e, tv[i].x_ad, tv[i].p_e, tv[i].x_par, tv[i].c_e);
      #1;
      chk($sformatf("vec%0d ad", i),   ad_pins,           tv[i].e_ad);
      chk($sformatf("vec%0d par", i),  par_pin,           tv[i].e_par);
      chk($sformatf("vec%0d perr", i), m_if.parity_error, tv[i].e_perr);
      @(posedge clk); #1;
    end

    do_reset();
    for (int c = 0; c < NR; c++) begin
      r_on[c]  = W'({$urandom, $urandom});
      r_en[c]  = ($urandom_range(0, 2) != 0);
      r_oe[c]  = ($urandom_range(0, 2) == 0);
      r_xe[c]  = !m_oeq(c) && ($urandom_range(0, 3) != 0);
      r_xad[c] = W'({$urandom, $urandom});
      r_pe[c]  = !m_paroe(c) && ($urandom_range(0, 3) != 0);
      r_xpar[c] = 1'($urandom);
      r_ce[c]  = 1'($urandom);
      drive(r_on[c], r_en[c], r_oe[c], r_xe[c], r_xad[c], r_pe[c], r_xpar[c], r_ce[c]);
      #1;
      chk($sformatf("rnd%0d ad", c),      ad_pins,              m_adpin(c));
      chk($sformatf("rnd%0d par", c),     par_pin,              m_parpin(c));
      chk($sformatf("rnd%0d comb", c),    m_if.pci_ad_in_comb,  m_adpin(c));
      chk($sformatf("rnd%0d prev", c),    m_if.pci_ad_in_prev,  (c > 0) ? m_adpin(c-1) : '0);
      chk($sformatf("rnd%0d parprev", c), m_if.pci_par_in_prev, (c > 0) ? m_parpin(c-1) : 1'b0);
      chk($sformatf("rnd%0d perr", c),    m_if.parity_error,    m_perr(c));
      chk($sformatf("rnd%0d oe", c),      m_if.pci_ad_oe_q,     m_oeq(c));
      @(posedge clk); #1;
    end

    // Reset mid-transfer with a check pending.
    a5 = 36'h0_A5A5_A5A5;
    do_reset();
    drive(a5, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(a5, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    #1 chk("mid ad driven", ad_pins, a5);
    @(posedge clk); #1;
    drive(a5, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("mid par driven", par_pin, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid rst ad z",     ad_pins,              ONES);
    chk("mid rst par z",    par_pin,              1'b1);
    chk("mid rst oe_q",     m_if.pci_ad_oe_q,     1'b0);
    chk("mid rst ad_prev",  m_if.pci_ad_in_prev,  '0);
    chk("mid rst par_prev", m_if.pci_par_in_prev, 1'b0);
    chk("mid rst perr",     m_if.parity_error,    1'b0);
    drive('0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post rst perr%0d", k), m_if.parity_error, 1'b0);
    end

    // Bypass loopback: pins fought by an external driver, receive path follows ad_q.
    @(negedge clk);
    b_if.pci_ad_out_next = 36'h0_1234_5678;
    b_if.pci_ad_out_en_next = 1'b1;
    b_if.pci_ad_oe_next = 1'b1;
    @(posedge clk); #1;
    b_if.pci_ad_out_en_next = 1'b0;
    b_xad = ~36'h0_1234_5678;
    b_xe = 1'b1;
    #1 chk("byp comb", b_if.pci_ad_in_comb, 36'h0_1234_5678);
    @(posedge clk); #1;
    chk("byp prev", b_if.pci_ad_in_prev, 36'h0_1234_5678);
    b_if.pci_ad_oe_next = 1'b0;
    b_xe = 1'b0;
    @(posedge clk); #1;
    b_xad = 36'h9_8765_4321;
    b_xe = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b1, 36'h0_1234_5678, 1'b0, 1'b0, 1'b0);
    #1;
    chk("byp idle comb",   b_if.pci_ad_in_comb, 36'h9_8765_4321);
    chk("pins mode comb",  m_if.pci_ad_in_comb, 36'h0_1234_5678);
    @(posedge clk); #1;
    chk("pins mode prev",  m_if.pci_ad_in_prev, 36'h0_1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/pci_registered_io_bank.md
Name: pci_registered_io_bank

Overview:
- Parametrised successor of the single-bit registered PCI pad: a WIDTH-bit bank of registered IO pads.
- Contains the output data flops with latch enable and the output-enable flop with asynchronous reset.
- Generates even PAR one clock after the AD data it covers, and checks received parity.
- Sits between the master/target state machines and the AD[31:0]+C/BE[3:0] (or AD[63:32]+C/BE[7:4]) pins; one instance per parity group.

Parameters:
- WIDTH, 36: number of pad bits covered by one PAR pin (32 AD + 4 C/BE).
- BYPASS_MODE, 0: 0 = inputs come from the pins only; 1 = inputs are looped back from the internal output flop while driving (PCI 2.2 sec 3.10 item 9).

Ports:
- pci_clk  in  1  PCI clock.
- pci_reset_comb  in  1  asynchronous, active-high reset.
- pci_ad_out_next  in  WIDTH  next output data.
- pci_ad_out_en_next  in  1  data latch enable; output flop loads when 1.
- pci_ad_oe_next  in  1  next output enable for the AD bank.
- pci_ad_ext  inout  WIDTH  pins.
- pci_par_ext  inout  1  PAR pin.
- pci_ad_in_comb  out  WIDTH  unregistered received data.
- pci_ad_in_prev  out  WIDTH  received data registered at the last pci_clk edge.
- pci_par_in_prev  out  1  received PAR registered at the last edge.
- parity_check_en  in  1  current cycle is a data phase to be parity-checked.
- parity_error  out  1  one-cycle pulse on a parity mismatch.
- pci_ad_oe_q  out  1  current AD output-enable state.

Behaviour:
- Reset: pci_reset_comb is asynchronous, active-high; clock is pci_clk.
  - While reset is asserted, all flops are 0 immediately, without waiting for a clock edge.
  - pci_ad_ext and pci_par_ext go Z at once.
  - pci_ad_in_prev = 0, pci_par_in_prev = 0, parity_error = 0, pci_ad_oe_q = 0.
- Output data flop ad_q: at each edge, ad_q <= pci_ad_out_en_next ? pci_ad_out_next : ad_q.
- OE flop: at each edge, pci_ad_oe_q <= pci_ad_oe_next.
- pci_ad_ext = pci_ad_oe_q ? ad_q : Z, per bit; all bits share one OE.
- Parity generation (even parity, PAR = XOR of all WIDTH bits of ad_q):
  - At each edge, par_q <= ^ad_q and par_oe_q <= pci_ad_oe_q.
  - pci_par_ext = par_oe_q ? par_q : Z.
  - PAR is therefore driven exactly one clock after the AD value it covers, and releases one clock after AD releases.
- Input path:
  - BYPASS_MODE=0: pci_ad_in_comb = pci_ad_ext.
  - BYPASS_MODE=1: pci_ad_in_comb = pci_ad_oe_q ? ad_q : pci_ad_ext.
  - The PAR input uses the same rule with par_oe_q/par_q.
  - At each edge, pci_ad_in_prev <= pci_ad_in_comb and pci_par_in_prev <= (PAR input).
- Parity check, two-stage pipeline:
  - Edge N: calc_q <= ^pci_ad_in_comb; chk_q <= parity_check_en.
  - Edge N+1: parity_error <= chk_q & (calc_q ^ PAR input).
  - parity_error is high for exactly the cycle after edge N+1.
  - Back-to-back checked phases produce independent, consecutive results with no bubble.
  - Z or X on the pins propagates as X; the bench must drive pins whenever a check is enabled.
- Turnaround: deasserting pci_ad_oe_next with the latch enable held still releases AD at the next edge; PAR remains driven one further cycle.
- Reset mid-transfer: outputs go Z asynchronously. Any pending check is discarded (chk_q = 0), so no parity_error follows reset release.
- Simulation-only check (translate_off): if the block is driving and the pin value !== ad_q at an edge, print a message with %m and $time.

Test Plan:
- Reset and OE release:
  - Stimulus: assert reset mid-transfer with oe=1, ad_q=32'hA5A5_A5A5/CBE=4'h0, with no clock edge.
  - Required: AD and PAR go Z within the same timestep; parity_error stays 0 after release.
- Drive and PAR timing:
  - Stimulus: edge 1 loads 36'h0_0000_0001 with oe=1; edge 2 loads 36'h0_0000_0003.
  - Required: AD shows 0x1 after edge 1; PAR=1 after edge 2; PAR=0 after edge 3.
- Latch-enable hold:
  - Stimulus: en=0 for 3 edges with pci_ad_out_next changing.
  - Required: AD holds its prior value and PAR stays constant.
- Parity check, good/bad:
  - Stimulus: external driver puts 36'h0_0000_0007 on AD with check_en=1; next cycle PAR=1, then repeat with PAR=0.
  - Required: parity_error=0 for the first phase; a one-cycle pulse two edges after the AD sample for the second.
- Back-to-back checks:
  - Stimulus: 4 consecutive checked phases with PAR wrong on phases 2 and 4.
  - Required: parity_error pattern 0,1,0,1 on consecutive cycles.
- BYPASS_MODE=1:
  - Stimulus: while driving 36'h0_1234_5678, force the pin via a weak external X.
  - Required: pci_ad_in_comb = 0x12345678 and pci_ad_in_prev matches next cycle; with mode 0 it shows the pin value.
